// File: rtl/snow64_mem_bus_responder.sv
// Memory-side responder for the Snow64 memory access port: whole-line reads
// and writes against a line-wide RAM with a fixed request-to-response latency.
module snow64_mem_bus_responder #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 64,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_req_valid,
  input  logic                  in_req_write,
  input  logic [ADDR_WIDTH-1:0] in_req_addr,
  input  logic [DATA_WIDTH-1:0] in_req_data,
  output logic                  out_busy,
  output logic                  out_rd_valid,
  output logic [DATA_WIDTH-1:0] out_rd_data,
  output logic                  out_wr_done,
  output logic                  out_addr_err
);

  localparam int LINES = 1 << DEPTH_LOG2;
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic                  wr_q;
  logic                  err_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] mem [LINES];

  logic accept;
  logic commit;
  logic req_err;
  logic unused_addr_lsbs;

  // Byte offset within the line plays no part in addressing a whole line.
  assign unused_addr_lsbs = ^in_req_addr[4:0];

  assign req_err = |in_req_addr[ADDR_WIDTH-1:DEPTH_LOG2+5];
  assign accept  = in_req_valid && ((state == ST_IDLE) || (state == ST_RESP));
  assign commit  = (state == ST_WAIT) && (cnt == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_RESP: begin
          if (accept) begin
            state <= ST_WAIT;
            cnt   <= CNT_W'(LATENCY - 2);
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) state <= ST_RESP;
          else           cnt   <= cnt - CNT_W'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Request attributes are only meaningful while a request is outstanding.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= 1'b0;
      err_q <= 1'b0;
    end else if (accept) begin
      wr_q  <= in_req_write;
      err_q <= req_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      idx_q  <= in_req_addr[DEPTH_LOG2+4:5];
      data_q <= in_req_data;
    end
  end

  // NOTE: the line RAM has no reset so it maps onto block RAM; its contents
  // survive rst by design.
  always_ff @(posedge clk) begin
    if (!rst && commit && wr_q && !err_q) mem[idx_q] <= data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (commit && !wr_q) begin
      rd_data_q <= err_q ? '0 : mem[idx_q];
    end
  end

  assign out_busy     = (state == ST_WAIT);
  assign out_rd_valid = (state == ST_RESP) && !wr_q;
  assign out_wr_done  = (state == ST_RESP) && wr_q;
  assign out_addr_err = (state == ST_RESP) && err_q;
  assign out_rd_data  = rd_data_q;

endmodule

// File: tb/tb_snow64_mem_bus_responder.sv
// Self-checking bench for snow64_mem_bus_responder: directed protocol steps
// followed by random line traffic checked against a line-store model.
module tb_snow64_mem_bus_responder;

  localparam int DW  = 256;
  localparam int AW  = 64;
  localparam int DL  = 10;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_req_valid;
  logic          in_req_write;
  logic [AW-1:0] in_req_addr;
  logic [DW-1:0] in_req_data;
  logic          out_busy;
  logic          out_rd_valid;
  logic [DW-1:0] out_rd_data;
  logic          out_wr_done;
  logic          out_addr_err;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] model [int];
  logic [DW-1:0] last_rd;

  snow64_mem_bus_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_LOG2(DL), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_req_valid(in_req_valid), .in_req_write(in_req_write),
    .in_req_addr(in_req_addr), .in_req_data(in_req_data),
    .out_busy(out_busy), .out_rd_valid(out_rd_valid),
    .out_rd_data(out_rd_data), .out_wr_done(out_wr_done),
    .out_addr_err(out_addr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".busy"}, DW'(out_busy), '0);
    check({tag, ".rd_valid"}, DW'(out_rd_valid), '0);
    check({tag, ".wr_done"}, DW'(out_wr_done), '0);
    check({tag, ".addr_err"}, DW'(out_addr_err), '0);
    check({tag, ".rd_data"}, out_rd_data, last_rd);
  endtask

  task automatic issue(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    in_req_valid = 1'b1;
    in_req_write = w;
    in_req_addr  = a;
    in_req_data  = d;
    tick();
    in_req_valid = 1'b0;
    in_req_data  = '0;
  endtask

  // Called in cycle T+1; returns in the response cycle T+LAT.
  task automatic expect_resp(input string tag, input bit w, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input bit poke);
    bit            err;
    int            idx;
    logic [DW-1:0] exp_rd;
    err = |a[AW-1:DL+5];
    idx = int'(a[DL+4:5]);
    for (int k = 1; k < LAT; k++) begin
      check({tag, ".wait_busy"}, DW'(out_busy), DW'(1));
      check({tag, ".wait_pulse"}, DW'(out_rd_valid | out_wr_done | out_addr_err), '0);
      if (poke && k == 1) begin
        in_req_valid = 1'b1;
        in_req_write = 1'b1;
        in_req_addr  = AW'(7) << 5;
        in_req_data  = {8{$urandom}};
      end
      tick();
      in_req_valid = 1'b0;
    end
    if (w && !err) model[idx] = d;
    check({tag, ".resp_busy"}, DW'(out_busy), '0);
    check({tag, ".rd_valid"}, DW'(out_rd_valid), DW'(!w));
    check({tag, ".wr_done"}, DW'(out_wr_done), DW'(w));
    check({tag, ".addr_err"}, DW'(out_addr_err), DW'(err));
    if (!w) begin
      exp_rd = err ? '0 : model[idx];
      check({tag, ".rd_data"}, out_rd_data, exp_rd);
      last_rd = exp_rd;
    end
  endtask

  task automatic op(input string tag, input bit w, input logic [AW-1:0] a,
                    input logic [DW-1:0] d, input bit poke);
    issue(w, a, d);
    expect_resp(tag, w, a, d, poke);
  endtask

  initial begin
    logic [DW-1:0] aa, c7, n3, p3;
    logic [AW-1:0] a;
    int            idx;
    bit            w, oor;

    aa = {32{8'hAA}};
    c7 = {32{8'hC7}};
    n3 = {32{8'h3C}};
    last_rd = '0;

    // Reset held two cycles with a request present: dropped entirely.
    rst = 1'b1; in_req_valid = 1'b1; in_req_write = 1'b1;
    in_req_addr = 64'h40; in_req_data = aa;
    tick(); check_quiet("rst_c1");
    tick(); check_quiet("rst_c2");
    rst = 1'b0; in_req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(); check_quiet("post_rst");
    end

    // Write then read of index 2 with a different byte offset.
    op("wr_40", 1'b1, 64'h40, aa, 1'b0);
    tick(); check_quiet("idle_after_wr");
    op("rd_5f", 1'b0, 64'h5F, '0, 1'b0);
    tick(); check_quiet("rd_hold");

    // Index 7 gets known data; a later write attempt issued mid-WAIT is ignored.
    op("wr_idx7", 1'b1, 64'hE0, c7, 1'b0);
    tick();
    op("rd_poke", 1'b0, 64'h40, '0, 1'b1);
    tick(); check_quiet("no_resp_after_poke");
    tick(); check_quiet("no_resp_after_poke2");
    op("rd_idx7", 1'b0, 64'hE0, '0, 1'b0);

    // Back-to-back: write index 3 accepted in the read's RESP cycle, then read it.
    issue(1'b1, 64'h60, n3);
    expect_resp("b2b_wr3", 1'b1, 64'h60, n3, 1'b0);
    issue(1'b0, 64'h60, '0);
    expect_resp("b2b_rd3", 1'b0, 64'h60, '0, 1'b0);
    tick(); check_quiet("b2b_idle");

    // Out-of-range read and write; index 0 must stay intact.
    op("wr_idx0", 1'b1, 64'h0, {8{32'h0BAD_F00D}}, 1'b0);
    tick();
    op("rd_oor", 1'b0, 64'h8000, '0, 1'b0);
    tick();
    op("wr_oor", 1'b1, 64'h8000, {32{8'h55}}, 1'b0);
    tick();
    op("rd_idx0", 1'b0, 64'h0, '0, 1'b0);
    tick();

    // Reset two cycles into a write: never committed, no completion pulse.
    p3 = model[3];
    issue(1'b1, 64'h60, {32{8'h11}});
    check("rst_mid.busy_t1", DW'(out_busy), DW'(1));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_rd = '0;
    check_quiet("rst_mid_t3");
    for (int i = 0; i < 6; i++) begin
      tick(); check_quiet("rst_mid_after");
    end
    op("rd_after_rst", 1'b0, 64'h60, '0, 1'b0);
    check("rst_mid.prior", out_rd_data, p3);
    tick();

    // Random traffic, sometimes chained in the RESP cycle.
    for (int i = 0; i < 40; i++) begin
      idx = $urandom_range(0, 15);
      oor = ($urandom_range(0, 5) == 0);
      a = (AW'(idx) << 5) | AW'($urandom_range(0, 31));
      if (oor) a[DL + 5 + $urandom_range(0, AW - DL - 6)] = 1'b1;
      w = (!oor && !model.exists(idx)) ? 1'b1 : 1'($urandom_range(0, 1));
      op("rand", w, a, {8{$urandom}}, 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) begin
        tick(); check_quiet("rand_idle");
      end
    end
    tick(); check_quiet("final_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
